// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the HI/LO multiply unit.
//   state_e        FSM state encoding (IDLE=00, RUN=01, DONE=10)
//   DEFAULT_WIDTH  default operand width
//   cnt_width()    width of the partial-product counter, clog2(w)+1
//   CNT_W          counter width for the default operand width
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int DEFAULT_WIDTH = 32;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/mult_abs.sv
// mult_abs: conditional two's-complement negate.
//   value_i  in   width  value to pass through or negate
//   neg_i    in   1      1 = output is -value_i
//   value_o  out  width  result
// Used for operand magnitudes at START and for the final product sign fix.
module mult_abs #(
  parameter int width = 32
) (
  input  logic [width-1:0] value_i,
  input  logic             neg_i,
  output logic [width-1:0] value_o
);

  assign value_o = neg_i ? (~value_i + width'(1'b1)) : value_i;

endmodule

// File: rtl/mult_unit.sv
// mult_unit: multicycle radix-2 shift-add multiplier with HI/LO registers.
//   CLK    in   1      rising-edge clock
//   RST_N  in   1      asynchronous active-low reset
//   START  in   1      request a multiply (accepted in IDLE or DONE)
//   SGN    in   1      signed multiply (only with MULT_SIGNED_EN)
//   A, B   in   width  multiplicand / multiplier
//   WE_HI  in   1      MTHI write strobe (ignored while BUSY)
//   WE_LO  in   1      MTLO write strobe (ignored while BUSY)
//   WD     in   width  MTHI/MTLO write data
//   BUSY   out  1      multiply in progress (state RUN)
//   DONE   out  1      one-cycle pulse, HI/LO hold the new product
//   HI/LO  out  width  upper / lower product halves
// Build option: define MULT_SIGNED_EN to enable signed multiplies via SGN.
// Without it SGN is ignored and every multiply is unsigned.
module mult_unit
  import mult_pkg::*;
#(
  parameter int width = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             SGN,
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  input  logic             WE_HI,
  input  logic             WE_LO,
  input  logic [width-1:0] WD,
  output logic             BUSY,
  output logic             DONE,
  output logic [width-1:0] HI,
  output logic [width-1:0] LO
);

  localparam int CW = cnt_width(width);
  localparam logic [CW-1:0] LAST = CW'(width - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*width-1:0] acc_q, acc_d;
  logic [2*width-1:0] mcand_q, mcand_d;   // multiplicand, shifted left each step
  logic [width-1:0]   mplier_q, mplier_d; // multiplier, shifted right each step
  logic               neg_q, neg_d;       // product needs negating at the end
  logic [width-1:0]   hi_q, hi_d;
  logic [width-1:0]   lo_q, lo_d;

  logic [width-1:0]   a_mag, b_mag;
  logic               start_neg;
  logic [2*width-1:0] acc_sum;
  logic [2*width-1:0] product;

  // Accumulator after this RUN edge; on the last edge it is the full magnitude.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef MULT_SIGNED_EN
  // Signed mode works on magnitudes and fixes the sign on the final load,
  // so the latency is identical to the unsigned case.
  assign start_neg = SGN & (A[width-1] ^ B[width-1]);

  mult_abs #(.width(width)) u_abs_a (
    .value_i (A),
    .neg_i   (SGN & A[width-1]),
    .value_o (a_mag)
  );

  mult_abs #(.width(width)) u_abs_b (
    .value_i (B),
    .neg_i   (SGN & B[width-1]),
    .value_o (b_mag)
  );

  mult_abs #(.width(2*width)) u_abs_p (
    .value_i (acc_sum),
    .neg_i   (neg_q),
    .value_o (product)
  );
`else
  logic unused_ok;

  assign start_neg = 1'b0;
  assign a_mag     = A;
  assign b_mag     = B;
  assign product   = acc_sum;
  assign unused_ok = ^{SGN, neg_q};
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        // NOTE: blocking assignments here; the later MT writes intentionally
        // override the defaults within the same evaluation.
        if (START) begin
          state_d  = ST_RUN;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = {{width{1'b0}}, a_mag};
          mplier_d = b_mag;
          neg_d    = start_neg;
        end else begin
          state_d = ST_IDLE;
        end
        // In DONE these override the half loaded on the previous edge.
        if (WE_HI) hi_d = WD;
        if (WE_LO) lo_d = WD;
      end
      ST_RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d      = ST_DONE;
          {hi_d, lo_d} = product;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign BUSY = (state_q == ST_RUN);
  assign DONE = (state_q == ST_DONE);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit: directed, table-driven bench for mult_unit (width 32).
// Expected values for signed vectors follow MULT_SIGNED_EN when it is defined.
module tb_mult_unit;

  logic        CLK;
  logic        RST_N;
  logic        START;
  logic        SGN;
  logic [31:0] A;
  logic [31:0] B;
  logic        WE_HI;
  logic        WE_LO;
  logic [31:0] WD;
  logic        BUSY;
  logic        DONE;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks = 0;
  int n_errors = 0;

  mult_unit #(.width(32)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .SGN   (SGN),
    .A     (A),
    .B     (B),
    .WE_HI (WE_HI),
    .WE_LO (WE_LO),
    .WD    (WD),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .HI    (HI),
    .LO    (LO)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic start_mult(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    A     = a;
    B     = b;
    SGN   = sgn;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  // Counts BUSY cycles until DONE is seen, bounded to 40 cycles.
  task automatic wait_done(output int busy_n, output logic got);
    busy_n = 0;
    got    = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (DONE) got = 1'b1;
      else begin
        if (BUSY) busy_n++;
        @(negedge CLK);
      end
    end
  endtask

  function automatic logic [31:0] sel(input logic [31:0] s, input logic [31:0] u);
`ifdef MULT_SIGNED_EN
    return s;
`else
    return u;
`endif
  endfunction

  initial begin
    int   busy_n;
    logic got;

    vecs[0] = '{32'd3,         32'd5,         1'b0, 32'h00000000, 32'h0000000F};
    vecs[1] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{32'hFFFFFFFD,  32'd5,         1'b1, sel(32'hFFFFFFFF, 32'h00000004), 32'hFFFFFFF1};
    vecs[3] = '{32'h80000000,  32'd2,         1'b0, 32'h00000001, 32'h00000000};
    vecs[4] = '{32'h12345678,  32'h10,        1'b0, 32'h00000001, 32'h23456780};
    vecs[5] = '{32'd0,         32'hFFFFFFFF,  1'b0, 32'h00000000, 32'h00000000};
    vecs[6] = '{32'h00010000,  32'h00010000,  1'b0, 32'h00000001, 32'h00000000};
    vecs[7] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1, sel(32'h00000000, 32'hFFFFFFFE), 32'h00000001};
    vecs[8] = '{32'd7,         32'hFFFFFFFE,  1'b1, sel(32'hFFFFFFFF, 32'h00000006), 32'hFFFFFFF2};

    RST_N = 1'b0; START = 1'b0; SGN = 1'b0; A = '0; B = '0;
    WE_HI = 1'b0; WE_LO = 1'b0; WD = '0;
    repeat (3) @(negedge CLK);
    check("reset_busy", {31'd0, BUSY}, 32'd0);
    check("reset_done", {31'd0, DONE}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);

    // Table-driven products.
    for (int i = 0; i < 9; i++) begin
      start_mult(vecs[i].a, vecs[i].b, vecs[i].sgn);
      wait_done(busy_n, got);
      check($sformatf("v%0d_busy_cycles", i), busy_n, 32'd32);
      check($sformatf("v%0d_done", i), {31'd0, got}, 32'd1);
      check($sformatf("v%0d_hi", i), HI, vecs[i].hi);
      check($sformatf("v%0d_lo", i), LO, vecs[i].lo);
      @(negedge CLK);
      check($sformatf("v%0d_done_pulse", i), {31'd0, DONE}, 32'd0);
      check($sformatf("v%0d_idle", i), {31'd0, BUSY}, 32'd0);
    end

    // START during RUN is ignored.
    start_mult(32'd3, 32'd5, 1'b0);
    repeat (9) @(negedge CLK);
    start_mult(32'd7, 32'd7, 1'b0);
    wait_done(busy_n, got);
    check("ign_busy_cycles", busy_n, 32'd22);
    check("ign_done", {31'd0, got}, 32'd1);
    check("ign_lo", LO, 32'h0000000F);
    check("ign_hi", HI, 32'h00000000);

    // START held in the DONE cycle: back-to-back accept, no IDLE gap.
    start_mult(32'd2, 32'd9, 1'b0);
    check("b2b_busy", {31'd0, BUSY}, 32'd1);
    check("b2b_lo_held", LO, 32'h0000000F);
    wait_done(busy_n, got);
    check("b2b_busy_cycles", busy_n, 32'd32);
    check("b2b_lo", LO, 32'h00000012);
    @(negedge CLK);

    // MTHI in IDLE takes effect, LO untouched.
    WE_HI = 1'b1; WD = 32'h12345678;
    @(negedge CLK);
    WE_HI = 1'b0;
    check("mthi_idle_hi", HI, 32'h12345678);
    check("mthi_idle_lo", LO, 32'h00000012);

    // MTHI during RUN is ignored; completion overwrites.
    start_mult(32'd6, 32'd7, 1'b0);
    repeat (4) @(negedge CLK);
    WE_HI = 1'b1; WE_LO = 1'b1; WD = 32'hDEADBEEF;
    @(negedge CLK);
    WE_HI = 1'b0; WE_LO = 1'b0;
    check("mthi_run_hi", HI, 32'h12345678);
    check("mtlo_run_lo", LO, 32'h00000012);
    wait_done(busy_n, got);
    check("run_done", {31'd0, got}, 32'd1);
    check("run_hi", HI, 32'h00000000);
    check("run_lo", LO, 32'h0000002A);

    // MTLO in DONE overrides the just-loaded half.
    WE_LO = 1'b1; WD = 32'hCAFEF00D;
    @(negedge CLK);
    WE_LO = 1'b0;
    check("mtlo_done_lo", LO, 32'hCAFEF00D);
    check("mtlo_done_hi", HI, 32'h00000000);

    // START and MTHI in the same IDLE cycle: both act, completion wins.
    WE_HI = 1'b1; WD = 32'hAAAA5555;
    start_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    WE_HI = 1'b0;
    check("both_hi", HI, 32'hAAAA5555);
    check("both_busy", {31'd0, BUSY}, 32'd1);
    wait_done(busy_n, got);
    check("both_done_hi", HI, 32'hFFFFFFFE);
    check("both_done_lo", LO, 32'h00000001);
    @(negedge CLK);

    // Reset mid-run discards the product.
    start_mult(32'd7, 32'd9, 1'b0);
    repeat (15) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_done", {31'd0, DONE}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (DONE || BUSY) got = 1'b1;
    end
    check("rst_no_done", {31'd0, got}, 32'd0);
    check("rst_lo_after", LO, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mult_unit.md
# mult_unit

Multicycle HI/LO multiply unit for the MIPS datapath. It computes a 2*width-bit product with radix-2 shift-add, one partial product per clock. The product is held in HI/LO registers, which feed the writeback select mux on MFHI/MFLO. A START/BUSY/DONE handshake lets control stall dependent instructions until the product is ready.

## Interface
- width, 32, operand width; HI and LO are each width bits

- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- START  in  1  request a multiply; sampled in IDLE or DONE only
- SGN  in  1  1 = signed multiply (effective only with MULT_SIGNED_EN)
- A  in  width  multiplicand
- B  in  width  multiplier
- WE_HI  in  1  MTHI write strobe
- WE_LO  in  1  MTLO write strobe
- WD  in  width  MTHI/MTLO write data
- BUSY  out  1  multiply in progress
- DONE  out  1  one-cycle pulse; HI/LO valid with new product
- HI  out  width  upper product register
- LO  out  width  lower product register

## Operation
- States:
  - IDLE: START=1 → RUN; A, B, SGN latched; counter=0; accumulator cleared.
  - RUN: each edge adds the shifted multiplicand if the current multiplier bit is 1, then shifts and increments the counter. After the width-th RUN edge → DONE, and HI/LO load the product.
  - DONE: DONE=1. START=1 → RUN (back-to-back accept, same actions as IDLE); else → IDLE.
- Arithmetic:
  - Product is exactly 2*width bits; no truncation.
  - HI = bits [2w-1:w], LO = bits [w-1:0].
- START during RUN is ignored; no queuing.
- WE_HI/WE_LO:
  - Ignored while BUSY=1.
  - In IDLE or DONE: the write takes effect on that edge.
  - In DONE, the write overrides the just-loaded product half.
- START and WE_x in the same IDLE cycle: both take effect. The later completion overwrites both HI and LO.
- Reset, asserted at any time including mid-RUN:
  - State → IDLE, counter=0, accumulator=0, HI=0, LO=0, BUSY=0, DONE=0.
  - The in-flight product is discarded.

## Timing
- START sampled on edge E0 → BUSY=1 from E0 through edge E0+width.
- HI/LO updated and DONE=1 after edge E0+width; latency width cycles (32 by default).
- BUSY is a registered state decode (BUSY=1 iff state=RUN). DONE=1 iff state=DONE.
- Back-to-back throughput: one product per width+1 cycles.
- HI/LO change only on completion, on an accepted WE_x, or on reset.

## Configuration
- MULT_SIGNED_EN defined:
  - With SGN=1 latched, operands are converted to magnitudes at START.
  - The final product is two's-complement negated before loading HI/LO when A[w-1]^B[w-1].
  - Latency is unchanged.
- MULT_SIGNED_EN undefined:
  - SGN is ignored; all multiplies are unsigned.
  - The SGN port remains present.

## Structure
- Shared package mult_pkg holds:
  - the state encoding IDLE=2'b00, RUN=2'b01, DONE=2'b10
  - the counter width constant, clog2(width)+1
- One sub-module, mult_abs:
  - width-parameterised conditional two's-complement negate
  - used for operand magnitude and product sign correction
  - instantiated only under MULT_SIGNED_EN

## Test plan
- Reset, then A=3, B=5, START pulse → BUSY high 32 cycles, then DONE pulse; HI=0x00000000, LO=0x0000000F.
- Unsigned A=B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- MULT_SIGNED_EN, SGN=1, A=0xFFFFFFFD (-3), B=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. Same stimulus without the macro → HI=0x00000004, LO=0xFFFFFFF1.
- START pulsed with A=7, B=7 at cycle 10 of a 3*5 run → ignored; result LO=0x0000000F. START held high in the DONE cycle → second run starts with no IDLE gap.
- WE_HI with WD=0x12345678 during RUN → HI unchanged. The same write in IDLE → HI=0x12345678 next cycle, LO untouched.
- RST_N low at cycle 16 of a run → HI=LO=0, BUSY=0 immediately. No DONE pulse follows after release.
